// File: rtl/gpo_pad_cfg_ctrl_if.sv
// Config handshake between the pad-config register block (master) and the
// per-pad controller (slave): four-phase level REQ/ACK plus the drive payload.
interface gpo_pad_cfg_ctrl_if;
    logic       CFG_REQ_I;
    logic [1:0] CFG_DS_I;
    logic       CFG_SR_I;
    logic       CFG_CO_I;
    logic [1:0] CFG_MODE_I;
    logic       CFG_ACK_O;
    logic       CFG_ERR_O;

    modport master (
        output CFG_REQ_I, CFG_DS_I, CFG_SR_I, CFG_CO_I, CFG_MODE_I,
        input  CFG_ACK_O, CFG_ERR_O
    );

    modport slave (
        input  CFG_REQ_I, CFG_DS_I, CFG_SR_I, CFG_CO_I, CFG_MODE_I,
        output CFG_ACK_O, CFG_ERR_O
    );
endinterface

// File: rtl/gpo_pad_cfg_ctrl.sv
// Glitch-free configuration sequencer for one EG1D80V GPO pad (blank, apply, bias wait, settle).
// Define GPO_PAD_CFG_CTRL_BIAS_SYNC_EN to pass BIAS_OK_I through a 2-flop synchronizer.
module gpo_pad_cfg_ctrl #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned BIAS_TO_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                     CLK_I,
    input  logic                     RSTN_I,
    gpo_pad_cfg_ctrl_if.slave        cfg,
    input  logic                     DATA_I,
    input  logic                     EN_I,
    input  logic                     BIAS_OK_I,
    output logic                     BUSY_O,
    output logic                     DO_O,
    output logic [1:0]               DS_O,
    output logic                     SR_O,
    output logic                     CO_O,
    output logic                     OE_O,
    output logic                     ODP_O,
    output logic                     ODN_O
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_APPLY,
        S_BIAS_WAIT,
        S_SETTLE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         lat_ds_q, lat_ds_d, lat_mode_q, lat_mode_d;
    logic               lat_sr_q, lat_sr_d, lat_co_q, lat_co_d;
    logic [1:0]         mode_q, mode_d, ds_q, ds_d;
    logic               sr_q, sr_d, co_q, co_d, odp_q, odp_d, odn_q, odn_d;
    logic               oe_q, oe_d, do_q, do_d, ack_q, ack_d, err_q, err_d;
    logic               block_q, block_d;
    logic               bias_ok, accept, bias_to, settle_end, bias_loss, oe_win;

`ifdef GPO_PAD_CFG_CTRL_BIAS_SYNC_EN
    logic [1:0] bias_sync_q;

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            bias_sync_q <= '0;
        end else begin
            bias_sync_q <= {bias_sync_q[0], BIAS_OK_I};
        end
    end

    assign bias_ok = bias_sync_q[1];
`else
    assign bias_ok = BIAS_OK_I;
`endif

    assign accept     = (state_q == S_IDLE) && cfg.CFG_REQ_I;
    assign bias_to    = (cnt_q == CNT_W'(BIAS_TO_CYC - 1));
    assign settle_end = (cnt_q == CNT_W'(SETTLE_CYC - 1));
    assign bias_loss  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (ds_q != 2'b00)
                        && !bias_ok && !accept;
    // Output window opens only once the FSM is parked: IDLE with no pending
    // request, or DONE after ACK has been raised. This keeps OE low from the
    // cycle after REQ is sampled until one cycle after ACK.
    assign oe_win     = ((state_q == S_IDLE) && !cfg.CFG_REQ_I) || ((state_q == S_DONE) && ack_q);

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cfg.CFG_REQ_I) state_d = S_DRAIN;
            S_DRAIN:     state_d = S_APPLY;
            S_APPLY:     state_d = (lat_ds_q != 2'b00) ? S_BIAS_WAIT : S_SETTLE;
            S_BIAS_WAIT: if (bias_ok || bias_to) state_d = S_SETTLE;
            S_SETTLE:    if (settle_end) state_d = S_DONE;
            S_DONE:      if (!cfg.CFG_REQ_I) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = '0;
        lat_ds_d   = lat_ds_q;
        lat_sr_d   = lat_sr_q;
        lat_co_d   = lat_co_q;
        lat_mode_d = lat_mode_q;
        mode_d     = mode_q;
        ds_d       = ds_q;
        sr_d       = sr_q;
        co_d       = co_q;
        odp_d      = odp_q;
        odn_d      = odn_q;
        err_d      = err_q;
        block_d    = block_q;
        do_d       = DATA_I;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lat_ds_d   = cfg.CFG_DS_I;
                    lat_sr_d   = cfg.CFG_SR_I;
                    lat_co_d   = cfg.CFG_CO_I;
                    lat_mode_d = cfg.CFG_MODE_I;
                    err_d      = 1'b0;
                    block_d    = 1'b0;
                end
            end
            S_APPLY: begin
                ds_d   = lat_ds_q;
                sr_d   = lat_sr_q;
                co_d   = lat_co_q;
                mode_d = lat_mode_q;
                odp_d  = (lat_mode_q == 2'b10);
                odn_d  = (lat_mode_q == 2'b01);
            end
            S_BIAS_WAIT: begin
                if (state_d == S_BIAS_WAIT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Timeout only when bias is still bad; a same-cycle good bias wins.
                if (!bias_ok && bias_to) begin
                    ds_d  = 2'b00;
                    err_d = 1'b1;
                end
            end
            S_SETTLE: cnt_d = cnt_q + 1'b1;
            default: ;
        endcase

        if (bias_loss) begin
            block_d = 1'b1;
            err_d   = 1'b1;
        end

        ack_d = (state_q == S_DONE) && !(ack_q && !cfg.CFG_REQ_I);
        oe_d  = EN_I && (mode_q != 2'b11) && !block_d && oe_win;
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            cnt_q      <= '0;
            lat_ds_q   <= '0;
            lat_sr_q   <= 1'b0;
            lat_co_q   <= 1'b0;
            lat_mode_q <= '1;
            mode_q     <= '1;
            ds_q       <= '0;
            sr_q       <= 1'b0;
            co_q       <= 1'b0;
            odp_q      <= 1'b0;
            odn_q      <= 1'b0;
            oe_q       <= 1'b0;
            do_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lat_ds_q   <= lat_ds_d;
            lat_sr_q   <= lat_sr_d;
            lat_co_q   <= lat_co_d;
            lat_mode_q <= lat_mode_d;
            mode_q     <= mode_d;
            ds_q       <= ds_d;
            sr_q       <= sr_d;
            co_q       <= co_d;
            odp_q      <= odp_d;
            odn_q      <= odn_d;
            oe_q       <= oe_d;
            do_q       <= do_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            block_q    <= block_d;
        end
    end

    assign BUSY_O        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DO_O          = do_q;
    assign DS_O          = ds_q;
    assign SR_O          = sr_q;
    assign CO_O          = co_q;
    assign OE_O          = oe_q;
    assign ODP_O         = odp_q;
    assign ODN_O         = odn_q;
    assign cfg.CFG_ACK_O = ack_q;
    assign cfg.CFG_ERR_O = err_q;

endmodule

// File: tb/tb_gpo_pad_cfg_ctrl.sv
// Directed bench for gpo_pad_cfg_ctrl with hand-computed cycle latencies
// (SETTLE_CYC=16, BIAS_TO_CYC=255); cycle 0 is the cycle REQ is raised.
module tb_gpo_pad_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data, en, bias;
    logic       busy, do_o, sr, co, oe, odp, odn;
    logic [1:0] ds;
    int         n_chk = 0;
    int         n_bad = 0;
    int         ack_cyc, oe_leak, ack_cnt, ack_first;

    always #5 clk = ~clk;

    gpo_pad_cfg_ctrl_if cfg ();

    gpo_pad_cfg_ctrl #(
        .SETTLE_CYC (16),
        .BIAS_TO_CYC(255),
        .CNT_W      (8)
    ) dut (
        .CLK_I    (clk),
        .RSTN_I   (rst_n),
        .cfg      (cfg),
        .DATA_I   (data),
        .EN_I     (en),
        .BIAS_OK_I(bias),
        .BUSY_O   (busy),
        .DO_O     (do_o),
        .DS_O     (ds),
        .SR_O     (sr),
        .CO_O     (co),
        .OE_O     (oe),
        .ODP_O    (odp),
        .ODN_O    (odn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise REQ with the given payload and run until ACK; bias_rise is the
    // cycle at which BIAS_OK_I is driven high (-1: leave unchanged).
    task automatic run_cfg(input logic [1:0] p_ds, input logic p_sr, input logic p_co,
                           input logic [1:0] p_mode, input int bias_rise,
                           output int a_cyc, output int leak);
        cfg.CFG_DS_I   = p_ds;
        cfg.CFG_SR_I   = p_sr;
        cfg.CFG_CO_I   = p_co;
        cfg.CFG_MODE_I = p_mode;
        cfg.CFG_REQ_I  = 1'b1;
        a_cyc = -1;
        leak  = 0;
        for (int c = 1; c <= 400 && a_cyc < 0; c++) begin
            tick();
            if (c == bias_rise) bias = 1'b1;
            if (cfg.CFG_ACK_O) a_cyc = c;
            else if (oe) leak++;
        end
    endtask

    task automatic release_req();
        cfg.CFG_REQ_I = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        data = 1'b0;
        en = 1'b1;
        bias = 1'b0;
        cfg.CFG_REQ_I = 1'b0;
        cfg.CFG_DS_I = 2'b00;
        cfg.CFG_SR_I = 1'b0;
        cfg.CFG_CO_I = 1'b0;
        cfg.CFG_MODE_I = 2'b00;

        // Reset: everything low, even with EN_I=1.
        repeat (3) tick();
        check("rst_outs", {busy, do_o, ds, sr, co, oe, odp, odn, cfg.CFG_ACK_O, cfg.CFG_ERR_O}, '0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_oe_hiz", oe, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // Push-pull, DS=00: ACK at cycle 20, OE back at 21.
        bias = 1'b1;
        run_cfg(2'b00, 1'b0, 1'b1, 2'b00, -1, ack_cyc, oe_leak);
        check("pp_ack_cyc", ack_cyc, 20);
        check("pp_oe_blanked", oe_leak, 0);
        check("pp_oe_at_ack", oe, 1'b0);
        tick();
        check("pp_oe_restored", oe, 1'b1);
        check("pp_co", co, 1'b1);
        check("pp_od", {odp, odn}, 2'b00);
        data = 1'b1;
        #2;
        check("do_delay_hold", do_o, 1'b0);
        tick();
        check("do_follow_1", do_o, 1'b1);
        cfg.CFG_REQ_I = 1'b0;
        data = 1'b0;
        tick();
        check("do_follow_0", do_o, 1'b0);
        check("pp_ack_drop", cfg.CFG_ACK_O, 1'b0);
        check("pp_oe_kept_idle", oe, 1'b1);
        tick();

        // DS=10, bias rises 5 cycles after APPLY (cycle 7): ACK 5 cycles later.
        bias = 1'b0;
        run_cfg(2'b10, 1'b1, 1'b0, 2'b00, 7, ack_cyc, oe_leak);
        check("bw_ack_cyc", ack_cyc, 25);
        check("bw_oe_blanked", oe_leak, 0);
        check("bw_err", cfg.CFG_ERR_O, 1'b0);
        check("bw_ds", ds, 2'b10);
        check("bw_sr", sr, 1'b1);
        release_req();

        // DS=11 with bias held low: 255 wait cycles, timeout, then settle.
        bias = 1'b0;
        run_cfg(2'b11, 1'b0, 1'b0, 2'b00, -1, ack_cyc, oe_leak);
        check("to_ack_cyc", ack_cyc, 275);
        check("to_ds_zeroed", ds, 2'b00);
        check("to_err", cfg.CFG_ERR_O, 1'b1);
        release_req();
        check("to_err_sticky", cfg.CFG_ERR_O, 1'b1);

        // Open-drain DS=01: new request clears ERR; ODN=1, ODP=0.
        bias = 1'b1;
        run_cfg(2'b01, 1'b0, 1'b0, 2'b01, -1, ack_cyc, oe_leak);
        check("od_ack_cyc", ack_cyc, 21);
        check("od_err_clr", cfg.CFG_ERR_O, 1'b0);
        check("od_pins", {odp, odn}, 2'b01);
        release_req();
        check("od_oe_idle", oe, 1'b1);

        // Bias loss in IDLE with DS=01: OE drops next cycle, ERR set, block sticky.
        bias = 1'b0;
        tick();
        check("loss_oe", oe, 1'b0);
        check("loss_err", cfg.CFG_ERR_O, 1'b1);
        bias = 1'b1;
        tick();
        tick();
        check("loss_block_sticky", oe, 1'b0);

        // Hi-Z mode: OE stays low after ACK; block cleared by the request.
        run_cfg(2'b00, 1'b0, 1'b0, 2'b11, -1, ack_cyc, oe_leak);
        check("hz_ack_cyc", ack_cyc, 20);
        check("hz_err_clr", cfg.CFG_ERR_O, 1'b0);
        tick();
        check("hz_oe", oe, 1'b0);
        check("hz_pins", {odp, odn}, 2'b00);
        release_req();

        // REQ dropped mid-sequence: single ACK pulse at cycle 20, OE at 21.
        cfg.CFG_DS_I = 2'b00;
        cfg.CFG_MODE_I = 2'b00;
        cfg.CFG_REQ_I = 1'b1;
        ack_cnt = 0;
        ack_first = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) cfg.CFG_REQ_I = 1'b0;
            if (cfg.CFG_ACK_O) begin
                ack_cnt++;
                if (ack_first < 0) ack_first = c;
            end
            if (c == 21) check("early_drop_oe21", oe, 1'b1);
        end
        check("early_drop_ack_first", ack_first, 20);
        check("early_drop_ack_pulses", ack_cnt, 1);
        check("early_drop_busy", busy, 1'b0);

        // Reset while in BIAS_WAIT: outputs clear immediately; clean restart.
        bias = 1'b0;
        cfg.CFG_DS_I = 2'b10;
        cfg.CFG_MODE_I = 2'b01;
        cfg.CFG_REQ_I = 1'b1;
        repeat (10) tick();
        check("mid_pre_ds", ds, 2'b10);
        check("mid_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {busy, do_o, ds, sr, co, oe, odp, odn, cfg.CFG_ACK_O, cfg.CFG_ERR_O}, '0);
        cfg.CFG_REQ_I = 1'b0;
        bias = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_cfg(2'b00, 1'b0, 1'b0, 2'b00, -1, ack_cyc, oe_leak);
        check("restart_ack_cyc", ack_cyc, 20);
        tick();
        check("restart_oe", oe, 1'b1);
        release_req();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
